// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (fetch/data) arbiter onto one shared memory port
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [63:0] dm_addr_i,
  input  logic [63:0] dm_wdata_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [63:0] dm_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic        owner_if_q, owner_if_d;
  logic [63:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [63:0] wdata_q, wdata_d;
  logic [3:0]  starve_q, starve_d;
  logic        drop_q, drop_d;

  logic        fetch_eff;
  logic        both_req;
  logic        grant_if;
  logic        grant_dm;

  // Arbitration: a flushing fetch does not compete; data wins unless fetch has starved.
  always_comb begin
    fetch_eff = if_req_i & ~if_flush_i;
    both_req  = fetch_eff & dm_req_i;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    if (state_q == ST_IDLE) begin
      grant_if = fetch_eff & (~dm_req_i | (starve_q == LIMIT));
      grant_dm = dm_req_i & ~grant_if;
    end
  end

  // State register: every flop is cleared asynchronously, abandoning any transaction.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      owner_if_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      starve_q   <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_if_q <= owner_if_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
      drop_q     <= drop_d;
    end
  end

  // Next state: latch the winner in IDLE, track starvation and fetch drops until the response.
  always_comb begin
    state_d    = state_q;
    owner_if_d = owner_if_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;
    drop_d     = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_if || grant_dm) begin
          state_d    = ST_REQ;
          owner_if_d = grant_if;
          addr_d     = grant_if ? if_addr_i : dm_addr_i;
          we_d       = grant_dm & dm_we_i;
          wdata_d    = grant_dm ? dm_wdata_i : '0;
          drop_d     = 1'b0;
          if (grant_if) begin
            starve_d = '0;
          end else if (both_req && (starve_q < LIMIT)) begin
            starve_d = 4'(starve_q + 4'd1);
          end
        end
      end
      ST_REQ: begin
        if (owner_if_q && if_flush_i) begin
          drop_d = 1'b1;
        end
        if (mem_ready_i) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (owner_if_q && if_flush_i) begin
          drop_d = 1'b1;
        end
        if (mem_rvalid_i) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: grants only in IDLE out of reset, memory drive in REQ, response steering in RESP.
  always_comb begin
    if_gnt_o    = 1'b0;
    dm_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    dm_rvalid_o = 1'b0;
    dm_rdata_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    busy_o      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if_gnt_o = grant_if & reset_ni;
        dm_gnt_o = grant_dm & reset_ni;
      end
      ST_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
      end
      ST_RESP: begin
        if (mem_rvalid_i) begin
          if (owner_if_q) begin
            if_rvalid_o = ~drop_q & ~if_flush_i;
            if (~drop_q & ~if_flush_i) begin
              if_rdata_o = addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
            end
          end else begin
            dm_rvalid_o = 1'b1;
            dm_rdata_o  = mem_rdata_i;
          end
        end
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk_i;
  logic        reset_ni;
  logic        if_req_i;
  logic [63:0] if_addr_i;
  logic        if_flush_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [63:0] dm_addr_i;
  logic [63:0] dm_wdata_i;
  logic        dm_gnt_o;
  logic        dm_rvalid_o;
  logic [63:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        busy_o;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_flush_i   (if_flush_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .dm_req_i     (dm_req_i),
    .dm_we_i      (dm_we_i),
    .dm_addr_i    (dm_addr_i),
    .dm_wdata_i   (dm_wdata_i),
    .dm_gnt_o     (dm_gnt_o),
    .dm_rvalid_o  (dm_rvalid_o),
    .dm_rdata_o   (dm_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ready_i  (mem_ready_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Requesters: a request stays pending until its grant is seen.
  bit          if_pend, dm_pend, dm_we_r;
  logic [63:0] if_addr_r, dm_addr_r, dm_wdata_r;

  // Reference model: one transaction in flight, described by who owns it and what it waits for.
  bit          m_busy;
  bit          m_wait_resp;
  bit          m_owner_if;
  bit          m_we;
  bit          m_drop;
  logic [63:0] m_addr, m_wdata;
  int          m_losses;

  bit          glog[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic new_fetch(input logic [63:0] a);
    if (!if_pend) begin
      if_pend   = 1'b1;
      if_addr_r = {a[63:2], 2'b00};
    end
  endtask

  task automatic new_data(input bit we, input logic [63:0] a, input logic [63:0] d);
    if (!dm_pend) begin
      dm_pend    = 1'b1;
      dm_we_r    = we;
      dm_addr_r  = a;
      dm_wdata_r = d;
    end
  endtask

  task automatic drive(input bit flush, input bit ready, input bit rv, input logic [63:0] rd);
    if_req_i     = if_pend;
    if_addr_i    = if_pend ? if_addr_r : 64'h0;
    if_flush_i   = flush;
    dm_req_i     = dm_pend;
    dm_we_i      = dm_pend ? dm_we_r : 1'b0;
    dm_addr_i    = dm_pend ? dm_addr_r : 64'h0;
    dm_wdata_i   = dm_pend ? dm_wdata_r : 64'h0;
    mem_ready_i  = ready;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
  endtask

  task automatic model_reset();
    m_busy      = 1'b0;
    m_wait_resp = 1'b0;
    m_drop      = 1'b0;
    m_losses    = 0;
  endtask

  // One clock: called just after a falling edge, returns just after the next falling edge.
  task automatic cycle(input bit flush, input bit ready, input bit rv, input logic [63:0] rd);
    bit eff_if, any_win, win_if, exp_ifv, exp_dmv;
    drive(flush, ready, rv, rd);
    #1;
    eff_if  = if_pend && !flush;
    any_win = !m_busy && (eff_if || dm_pend);
    win_if  = any_win && eff_if && (!dm_pend || m_losses == LIMIT);
    chk("if_gnt", {63'h0, if_gnt_o}, {63'h0, win_if});
    chk("dm_gnt", {63'h0, dm_gnt_o}, {63'h0, any_win && !win_if});
    chk("busy", {63'h0, busy_o}, {63'h0, m_busy});
    chk("mem_req", {63'h0, mem_req_o}, {63'h0, m_busy && !m_wait_resp});
    if (m_busy && !m_wait_resp) begin
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_we", {63'h0, mem_we_o}, {63'h0, m_we});
      if (!m_owner_if) chk("mem_wdata", mem_wdata_o, m_wdata);
    end
    exp_ifv = m_busy && m_wait_resp && rv && m_owner_if && !m_drop && !flush;
    exp_dmv = m_busy && m_wait_resp && rv && !m_owner_if;
    chk("if_rvalid", {63'h0, if_rvalid_o}, {63'h0, exp_ifv});
    chk("dm_rvalid", {63'h0, dm_rvalid_o}, {63'h0, exp_dmv});
    if (exp_ifv) chk("if_rdata", {32'h0, if_rdata_o}, {32'h0, (m_addr[2] ? rd[63:32] : rd[31:0])});
    if (exp_dmv && !m_we) chk("dm_rdata", dm_rdata_o, rd);
    if (if_gnt_o || dm_gnt_o) glog.push_back(if_gnt_o);
    @(posedge clk_i);
    if (any_win) begin
      m_busy      = 1'b1;
      m_wait_resp = 1'b0;
      m_drop      = 1'b0;
      m_owner_if  = win_if;
      if (win_if) begin
        m_losses = 0;
        m_addr   = if_addr_r;
        m_we     = 1'b0;
        if_pend  = 1'b0;
      end else begin
        if (eff_if && m_losses < LIMIT) m_losses++;
        m_addr  = dm_addr_r;
        m_we    = dm_we_r;
        m_wdata = dm_wdata_r;
        dm_pend = 1'b0;
      end
    end else if (m_busy) begin
      if (m_owner_if && flush) m_drop = 1'b1;
      if (!m_wait_resp && ready) m_wait_resp = 1'b1;
      else if (m_wait_resp && rv) m_busy = 1'b0;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    if_pend  = 1'b1;
    dm_pend  = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 64'h0);
    repeat (2) @(negedge clk_i);
    chk("rst_busy", {63'h0, busy_o}, 64'h0);
    chk("rst_if_gnt", {63'h0, if_gnt_o}, 64'h0);
    chk("rst_dm_gnt", {63'h0, dm_gnt_o}, 64'h0);
    chk("rst_mem_req", {63'h0, mem_req_o}, 64'h0);
    if_pend  = 1'b0;
    dm_pend  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    reset_ni = 1'b1;
    model_reset();
  endtask

  initial begin
    reset_ni = 1'b0;
    if_pend  = 1'b0;
    dm_pend  = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    @(negedge clk_i);
    do_reset();

    // Single fetch at 0x1004 picks the upper instruction word.
    new_fetch(64'h1004);
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 64'hAAAA_BBBB_1111_2222);
    cycle(1'b0, 1'b0, 1'b0, 64'h0);

    // Continuous contention: fetch gets every fifth grant.
    do_reset();
    glog.delete();
    repeat (30) begin
      new_fetch({$urandom, $urandom});
      new_data(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      cycle(1'b0, 1'b1, 1'b1, {$urandom, $urandom});
    end
    chk("starve_ngrants", 64'(glog.size()), 64'd10);
    for (int i = 0; i < glog.size(); i++)
      chk("starve_order", {63'h0, glog[i]}, {63'h0, (i % 5 == 4)});

    // Write held off by mem_ready for three cycles, then acknowledged.
    do_reset();
    new_data(1'b1, 64'h2000, 64'h55);
    cycle(1'b0, 1'b0, 1'b0, 64'h0);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 64'h0);
    cycle(1'b0, 1'b1, 1'b0, 64'h0);
    cycle(1'b0, 1'b0, 1'b1, 64'hDEAD);
    cycle(1'b0, 1'b0, 1'b0, 64'h0);

    // Flush during RESP drops the fetch response; the next fetch still goes through.
    new_fetch(64'h40);
    cycle(1'b0, 1'b0, 1'b0, 64'h0);
    cycle(1'b0, 1'b1, 1'b0, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    cycle(1'b0, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0);
    new_fetch(64'h80);
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0);

    // Asynchronous reset while waiting for a response, then a late mem_rvalid.
    new_fetch(64'h100);
    cycle(1'b0, 1'b0, 1'b0, 64'h0);
    cycle(1'b0, 1'b1, 1'b0, 64'h0);
    new_data(1'b0, 64'h300, 64'h0);
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    #2 reset_ni = 1'b0;
    #1;
    chk("async_busy", {63'h0, busy_o}, 64'h0);
    chk("async_mem_req", {63'h0, mem_req_o}, 64'h0);
    chk("async_mem_addr", mem_addr_o, 64'h0);
    chk("async_dm_gnt", {63'h0, dm_gnt_o}, 64'h0);
    chk("async_if_rvalid", {63'h0, if_rvalid_o}, 64'h0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    model_reset();
    repeat (4) cycle(1'b0, 1'b1, 1'b1, 64'hFEED_0000_CAFE_0000);

    // Randomized traffic with random flushes and memory latency.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) new_fetch({$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) new_data(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 2) != 0, {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, consecutive fetch losses before fetch gets forced priority (range 1-15).
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 if_req_i  input  1  fetch request; held until if_gnt_o.
REQ-005 if_addr_i  input  64  fetch byte address, 4-byte aligned.
REQ-006 if_flush_i  input  1  pipeline flush; cancels pending fetch response.
REQ-007 if_gnt_o  output  1  one-cycle fetch grant.
REQ-008 if_rvalid_o / if_rdata_o  output  1 / 32  fetch response pulse and instruction word.
REQ-009 dm_req_i / dm_we_i  input  1 / 1  data request, write enable; held until dm_gnt_o.
REQ-010 dm_addr_i / dm_wdata_i  input  64 / 64  data address and write data.
REQ-011 dm_gnt_o  output  1  one-cycle data grant.
REQ-012 dm_rvalid_o / dm_rdata_o  output  1 / 64  data response pulse (read data or write ack).
REQ-013 mem_req_o / mem_we_o  output  1 / 1  shared memory request, write enable.
REQ-014 mem_addr_o / mem_wdata_o  output  64 / 64  shared memory address and write data.
REQ-015 mem_ready_i  input  1  memory accepts request this cycle.
REQ-016 mem_rvalid_i / mem_rdata_i  input  1 / 64  memory response pulse and 64-bit data.
REQ-017 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states IDLE, REQ, RESP; exactly one memory transaction outstanding.
REQ-019 IDLE, no request -> stay IDLE, all grant/valid outputs 0.
REQ-020 IDLE, request present -> assert winner's gnt_o combinationally that cycle, latch owner/addr/we/wdata, next REQ.
REQ-021 Priority: data over fetch, except when starve count equals STARVE_LIMIT and both request -> fetch wins.
REQ-022 Starve count: +1 when both request and data wins; cleared when fetch granted; saturates at STARVE_LIMIT.
REQ-023 if_req_i ignored in any cycle where if_flush_i=1 (no fetch grant that cycle).
REQ-024 REQ: mem_req_o=1 driving latched addr/we/wdata, stable until mem_ready_i=1 -> next RESP.
REQ-025 RESP: wait for mem_rvalid_i; on it, pulse owner's rvalid_o same cycle, next IDLE.
REQ-026 Fetch data: mem_rdata_i[31:0] when latched addr[2]=0, else mem_rdata_i[63:32]; dm_rdata_o = mem_rdata_i.
REQ-027 Writes complete via mem_rvalid_i; dm_rvalid_o pulses as write ack, dm_rdata_o don't-care.
REQ-028 Fetch-owned transaction with if_flush_i=1 in REQ or RESP: mark dropped; FSM sequence unchanged; if_rvalid_o suppressed for that response.
REQ-029 No re-arbitration in the cycle the response returns; minimum 3 cycles per transaction, back-to-back grants 3 cycles apart.
REQ-030 mem_rvalid_i outside RESP ignored; mem_ready_i outside REQ ignored.

Reset
REQ-031 reset_ni=0 immediately forces IDLE, starve count 0, drop flag 0, all outputs 0, independent of clk_i.
REQ-032 Reset mid-transaction abandons it; no rvalid pulse is produced for it after release.
REQ-033 First arbitration possible on first rising edge with reset_ni=1.

Verification
REQ-034 Fetch only, addr 0x1004, ready/rvalid immediate, mem_rdata 0xAAAA_BBBB_1111_2222 -> if_gnt cycle 0, mem_req cycle 1, if_rvalid cycle 2, if_rdata 0xAAAA_BBBB.
REQ-035 Both requesting continuously, STARVE_LIMIT=4 -> grants DM,DM,DM,DM,IF,DM... repeating.
REQ-036 Data write 0x2000, data 0x55, mem_ready held low 3 cycles -> mem_req_o/addr/wdata stable 4 cycles, then dm_rvalid ack.
REQ-037 Fetch in RESP, if_flush_i pulsed -> no if_rvalid_o, busy_o drops after mem_rvalid_i, next fetch granted.
REQ-038 reset_ni low in RESP between clock edges -> outputs 0 immediately; late mem_rvalid_i after release yields no rvalid.
